// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: word storage with byte-lane writes, optional wait states, two-cycle ERROR.
// Data phase follows address phase; HREADYOUT low for WAIT_STATES cycles per OKAY transfer, 1 cycle on ERROR.
module ahb_lite_mem_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [1:0]        HTRANS,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);
    localparam int NB    = DATA_W / 8;
    localparam int LB    = $clog2(NB);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              act_q, act_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LB-1:0]     off_q, off_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              legal, ready, accept, done;
    logic [NB-1:0]     be;
    logic              unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    always_comb begin
        legal = 1'b1;
        if (int'(HSIZE) > LB) legal = 1'b0;
        for (int b = 0; b < LB; b++) begin
            if ((b < int'(HSIZE)) && HADDR[b]) legal = 1'b0;
        end
        if ((HADDR >> (LB + IDX_W)) != '0) legal = 1'b0;
    end

    assign ready  = !((state_q == S_ERR1) || ((state_q == S_WAIT) && (cnt_q != 4'd0)));
    assign accept = HSEL && HREADY && HTRANS[1] && ready;
    // act_q only ever holds a legal transfer, so done never fires in the error states
    assign done   = act_q && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        idx_d   = idx_q;
        off_d   = off_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = S_IDLE;
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: ;
        endcase
        if (ready) begin
            act_d = 1'b0;
            if (accept) begin
                idx_d   = HADDR[LB+IDX_W-1:LB];
                off_d   = HADDR[LB-1:0];
                write_d = HWRITE;
                size_d  = HSIZE;
                if (!legal) begin
                    state_d = S_ERR1;
                end else begin
                    act_d = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            act_q   <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            be[b] = (b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q));
        end
    end

    // Storage is never cleared; a write caught by reset on its commit edge is dropped
    always_ff @(posedge HCLK) begin
        if (HRESETn && done && write_q) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HREADYOUT = ready;
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA    = (done && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: zero-wait instance driven from a vector table, three-wait instance by hand.
module tb_ahb_lite_mem_slave;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        hresetn, hsel, hwrite, use3;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        rdy0, resp0, rdy3, resp3;
    logic [31:0] rdata0, rdata3;

    int total = 0;
    int bad   = 0;

    ahb_lite_mem_slave #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && !use3), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HWDATA(hwdata), .HREADY(rdy0),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_lite_mem_slave #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u3 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel && use3), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HWDATA(hwdata), .HREADY(rdy3),
        .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rd;
        logic        ck_rd;
    } vec_t;

    vec_t tv[$];

    localparam logic [1:0] ID = 2'd0, BS = 2'd1, NS = 2'd2, SQ = 2'd3;

    function automatic vec_t v(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                               input logic wr, input logic [2:0] sz, input logic [31:0] wd,
                               input logic er, input logic es, input logic [31:0] ed,
                               input logic ck);
        vec_t r;
        r.sel = sel; r.tr = tr; r.addr = a; r.wr = wr; r.sz = sz; r.wd = wd;
        r.e_rdy = er; r.e_resp = es; r.e_rd = ed; r.ck_rd = ck;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = ID; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    endtask

    // One transfer on the three-wait instance; counts HREADYOUT-low cycles of its data phase
    task automatic xfer3(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic ck_rd, input string nm);
        int low;
        low = 0;
        hsel = 1'b1; htrans = NS; haddr = addr; hwrite = wr; hsize = 3'd2;
        @(posedge clk); #1;
        bus_idle();
        hwdata = wdata;
        @(negedge clk);
        while (!rdy3 && low < 20) begin
            low++;
            @(negedge clk);
        end
        check({nm, "_lowcycles"}, low, 32'd3);
        check({nm, "_resp"}, 32'(resp3), 32'd0);
        if (ck_rd) check({nm, "_rdata"}, rdata3, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        hresetn = 1'b0; use3 = 1'b0; hwdata = '0; hburst = 3'd0; hprot = 4'd3;
        bus_idle();

        // Rows: address phase of this cycle + write data / expected outputs of the previous row's transfer
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'h0,        1));
        tv.push_back(v(1, NS, 32'h010, 1, 2, 32'h0,        1, 0, 32'h0,        1));
        tv.push_back(v(1, NS, 32'h010, 0, 2, 32'hDEADBEEF, 1, 0, 32'h0,        0));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'hDEADBEEF, 1));
        tv.push_back(v(1, NS, 32'h020, 1, 2, 32'h0,        1, 0, 32'h0,        0));
        tv.push_back(v(1, NS, 32'h021, 1, 0, 32'h11223344, 1, 0, 32'h0,        0));
        tv.push_back(v(1, NS, 32'h020, 0, 2, 32'h0000AA00, 1, 0, 32'h0,        0));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'h1122AA44, 1));
        tv.push_back(v(1, NS, 32'h002, 0, 2, 32'h0,        1, 0, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        0, 1, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 1, 32'h0,        1));
        tv.push_back(v(1, NS, 32'h1000, 0, 2, 32'h0,       1, 0, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        0, 1, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 1, 32'h0,        1));
        tv.push_back(v(1, NS, 32'h020, 0, 2, 32'h0,        1, 0, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'h1122AA44, 1));
        tv.push_back(v(1, NS, 32'h022, 1, 1, 32'h0,        1, 0, 32'h0,        1));
        tv.push_back(v(1, NS, 32'h020, 0, 2, 32'hBEEF0000, 1, 0, 32'h0,        0));
        tv.push_back(v(0, NS, 32'h020, 0, 2, 32'h0,        1, 0, 32'hBEEFAA44, 1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'h0,        0));
        tv.push_back(v(1, NS, 32'h021, 0, 1, 32'h0,        1, 0, 32'h0,        0));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        0, 1, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 1, 32'h0,        1));
        tv.push_back(v(1, NS, 32'h020, 1, 3, 32'h0,        1, 0, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'hFFFFFFFF, 0, 1, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 1, 32'h0,        1));
        tv.push_back(v(1, NS, 32'h020, 0, 2, 32'h0,        1, 0, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'hBEEFAA44, 1));
        tv.push_back(v(1, BS, 32'h020, 0, 2, 32'h0,        1, 0, 32'h0,        1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'h0,        0));
        tv.push_back(v(1, NS, 32'hFFC, 1, 2, 32'h0,        1, 0, 32'h0,        0));
        tv.push_back(v(1, NS, 32'hFFC, 0, 2, 32'hCAFEF00D, 1, 0, 32'h0,        0));
        tv.push_back(v(1, SQ, 32'h010, 0, 2, 32'h0,        1, 0, 32'hCAFEF00D, 1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'hDEADBEEF, 1));
        tv.push_back(v(1, ID, 32'h000, 0, 2, 32'h0,        1, 0, 32'h0,        1));

        repeat (2) @(posedge clk);
        #1;
        hresetn = 1'b1;

        @(negedge clk);
        check("rst3_rdy", 32'(rdy3), 32'd1);
        check("rst3_resp", 32'(resp3), 32'd0);
        check("rst3_rdata", rdata3, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < tv.size(); i++) begin
            hsel = tv[i].sel; htrans = tv[i].tr; haddr = tv[i].addr;
            hwrite = tv[i].wr; hsize = tv[i].sz; hwdata = tv[i].wd;
            @(negedge clk);
            check($sformatf("v%0d_rdy", i), 32'(rdy0), 32'(tv[i].e_rdy));
            check($sformatf("v%0d_resp", i), 32'(resp0), 32'(tv[i].e_resp));
            if (tv[i].ck_rd) check($sformatf("v%0d_rdata", i), rdata0, tv[i].e_rd);
            @(posedge clk); #1;
        end

        use3 = 1'b1;
        bus_idle();
        xfer3(1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0, "w3_wr0");
        xfer3(1'b1, 32'h8, 32'h12345678, 32'h0, 1'b0, "w3_wr8");
        xfer3(1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b1, "w3_rd0");

        // Reset lands in the middle of a write's wait states
        hsel = 1'b1; htrans = NS; haddr = 32'h8; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'h00000055;
        @(negedge clk);
        check("w3_rstwait_rdy", 32'(rdy3), 32'd0);
        @(posedge clk); #1;
        hresetn = 1'b0;
        @(posedge clk); #1;
        check("w3_postrst_rdy", 32'(rdy3), 32'd1);
        check("w3_postrst_resp", 32'(resp3), 32'd0);
        check("w3_postrst_rdata", rdata3, 32'h0);
        hresetn = 1'b1;
        @(posedge clk); #1;
        xfer3(1'b0, 32'h8, 32'h0, 32'h12345678, 1'b1, "w3_rd8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 Parameter ADDR_W, default 32, HADDR width in bits.
REQ-002 Parameter DATA_W, default 32, data bus width; legal values 32 or 64.
REQ-003 Parameter MEM_DEPTH, default 1024, storage depth in DATA_W words; power of two.
REQ-004 Parameter WAIT_STATES, default 0, HREADYOUT-low cycles inserted per OKAY transfer; legal range 0..15.
REQ-005 Port HCLK, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port HRESETn, input, 1, reset; synchronous, active-low.
REQ-007 Port HSEL, input, 1, slave select.
REQ-008 Port HADDR, input, ADDR_W, byte address.
REQ-009 Port HWRITE, input, 1, 1 = write, 0 = read.
REQ-010 Port HSIZE, input, 3, transfer size, 2^HSIZE bytes.
REQ-011 Port HBURST, input, 3, burst type; accepted, no functional effect.
REQ-012 Port HPROT, input, 4, protection; accepted, no functional effect.
REQ-013 Port HTRANS, input, 2, IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-014 Port HWDATA, input, DATA_W, write data, valid in the data phase.
REQ-015 Port HREADY, input, 1, bus-level ready; a transfer is sampled only when this is high.
REQ-016 Port HREADYOUT, output, 1, slave ready.
REQ-017 Port HRESP, output, 1, 0 = OKAY, 1 = ERROR.
REQ-018 Port HRDATA, output, DATA_W, read data.

Function
REQ-019 Address phase accepted when HSEL=1, HREADY=1 and HTRANS[1]=1; the block shall register HADDR, HWRITE and HSIZE.
REQ-020 An IDLE or BUSY transfer, or HSEL=0, shall produce a zero-wait OKAY data phase with no storage access.
REQ-021 The FSM shall have four states: IDLE, WAIT, ERR1, ERR2.
REQ-022 IDLE -> WAIT on a legal accepted transfer when WAIT_STATES>0.
REQ-023 IDLE -> ERR1 on an illegal accepted transfer; otherwise the FSM remains in IDLE.
REQ-024 In WAIT, a down-counter loaded with WAIT_STATES shall hold HREADYOUT=0 for exactly WAIT_STATES cycles; the FSM then completes the transfer and returns to IDLE.
REQ-025 With WAIT_STATES=0, legal transfers shall complete in one data-phase cycle, back-to-back, with HREADYOUT=1.
REQ-026 A transfer is illegal if 2^HSIZE > DATA_W/8.
REQ-027 A transfer is illegal if HADDR is not aligned to 2^HSIZE.
REQ-028 A transfer is illegal if its word index (HADDR >> log2(DATA_W/8)) >= MEM_DEPTH.
REQ-029 Error response: ERR1 drives HREADYOUT=0, HRESP=1; ERR2 drives HREADYOUT=1, HRESP=1; ERR2 then goes to IDLE.
REQ-030 An illegal transfer shall not modify storage, and HRDATA shall be 0 during ERR1 and ERR2.
REQ-031 Writes shall commit HWDATA on the completing data-phase cycle, updating only byte lanes selected by HSIZE and HADDR low bits, little-endian.
REQ-032 Reads shall present the full addressed word on HRDATA in the cycle HREADYOUT=1; unselected lanes carry stored contents.
REQ-033 A read addressed to the word written in the immediately preceding data phase shall return the merged new data (write forwarding), with no extra wait.
REQ-034 While HREADYOUT=0, address-phase inputs shall be ignored; the registered control shall be held.

Reset
REQ-035 While HRESETn=0 at a rising HCLK edge, the block shall set FSM=IDLE, wait counter=0, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-036 Reset shall discard any pending registered transfer; a write in progress shall not commit, and storage contents are otherwise undefined-preserved (not cleared).

Verification
REQ-037 WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back -> read returns 0xDEADBEEF via forwarding, HREADYOUT=1 every cycle.
REQ-038 WAIT_STATES=3: NONSEQ read @0x0 -> HREADYOUT low for exactly 3 cycles, data and OKAY in the 4th.
REQ-039 Byte write 0xAA @0x21 over stored 0x11223344 @0x20 -> read @0x20 returns 0x1122AA44.
REQ-040 Read word @0x2 (misaligned) and read @(MEM_DEPTH*4) -> each gives two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1), storage unchanged.
REQ-041 HRESETn low during WAIT of a write 0x55 @0x8 -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; later read @0x8 returns prior contents.
